// File: rtl/reg_writeback.sv
// Register-file write-port arbiter: ALU results and in-order load returns
// share one write port; a tag FIFO tracks outstanding load destinations.
module reg_writeback #(
  parameter int LQ_DEPTH = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        AluWre,
  input  logic [3:0]  AluReg,
  input  logic [15:0] AluData,
  input  logic        LoadIssue,
  input  logic [3:0]  LoadReg,
  input  logic        LoadValid,
  input  logic [15:0] LoadData,
  output logic        LoadAccept,
  output logic        Stall,
  output logic        RegWre,
  output logic [3:0]  WriteReg,
  output logic [15:0] WriteData,
  output logic [15:0] Busy,
  output logic        Err
);

  localparam int PW = $clog2(LQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(LQ_DEPTH);

  logic [3:0]    tags [LQ_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nx;
  logic [CW-1:0] pend    [16];
  logic [CW-1:0] pend_nx [16];
  logic [15:0]   busy_nx;
  logic [3:0]    head;
  logic          push;
  logic          pop;
  logic          empty;
  logic          err_nx;

  assign head  = tags[rd_ptr];
  assign empty = (count == '0);

  // Reset gates the accept so memory holds its return across reset.
  assign pop  = LoadValid & ~empty & ~AluWre & ~Rst;
  assign push = LoadIssue & ~Stall;

  assign LoadAccept = pop;

  always_comb begin
    count_nx = count + CW'(push) - CW'(pop);
    busy_nx  = '0;
    for (int r = 0; r < 16; r++) begin
      pend_nx[r] = pend[r]
                 + CW'(push && (LoadReg == 4'(r)))
                 - CW'(pop && (head == 4'(r)));
      busy_nx[r] = (pend_nx[r] != '0);
    end
  end

  always_comb begin
    err_nx = 1'b0;
    if (LoadIssue && Stall)
      err_nx = 1'b1;
    if (LoadValid && empty)
      err_nx = 1'b1;
    if (AluWre && Busy[AluReg])
      err_nx = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      Stall     <= 1'b0;
      Busy      <= '0;
      Err       <= 1'b0;
      for (int r = 0; r < 16; r++)
        pend[r] <= '0;
    end else begin
      if (push) begin
        tags[wr_ptr] <= LoadReg;
        wr_ptr       <= wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      count <= count_nx;
      Stall <= (count_nx == FULL);
      Busy  <= busy_nx;
      Err   <= Err | err_nx;
      for (int r = 0; r < 16; r++)
        pend[r] <= pend_nx[r];
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      RegWre    <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
    end else begin
      unique case (1'b1)
        AluWre: begin
          RegWre    <= 1'b1;
          WriteReg  <= AluReg;
          WriteData <= AluData;
        end
        pop: begin
          RegWre    <= 1'b1;
          WriteReg  <= head;
          WriteData <= LoadData;
        end
        default: RegWre <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: scoreboard of expected writes checked at negedge,
// plus per-scenario checks of handshake, busy, stall and error flags.
module tb_reg_writeback;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [3:0]  r;
    logic [15:0] d;
  } wr_t;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        AluWre;
  logic [3:0]  AluReg;
  logic [15:0] AluData;
  logic        LoadIssue;
  logic [3:0]  LoadReg;
  logic        LoadValid;
  logic [15:0] LoadData;
  logic        LoadAccept;
  logic        Stall;
  logic        RegWre;
  logic [3:0]  WriteReg;
  logic [15:0] WriteData;
  logic [15:0] Busy;
  logic        Err;

  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;
  wr_t  sb [$];
  logic [3:0] mq [$];

  reg_writeback #(.LQ_DEPTH(DEPTH)) dut (
    .Clk(Clk), .Rst(Rst),
    .AluWre(AluWre), .AluReg(AluReg), .AluData(AluData),
    .LoadIssue(LoadIssue), .LoadReg(LoadReg),
    .LoadValid(LoadValid), .LoadData(LoadData),
    .LoadAccept(LoadAccept), .Stall(Stall),
    .RegWre(RegWre), .WriteReg(WriteReg), .WriteData(WriteData),
    .Busy(Busy), .Err(Err)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (mon_en) begin
      checks++;
      if (sb.size() > 0) begin
        wr_t e;
        e = sb.pop_front();
        if (RegWre !== 1'b1 || WriteReg !== e.r || WriteData !== e.d) begin
          failures++;
          $display("FAIL write got=%b/%h/%h exp=1/%h/%h",
                   RegWre, WriteReg, WriteData, e.r, e.d);
        end
      end else if (RegWre !== 1'b0) begin
        failures++;
        $display("FAIL spurious_write got=%b exp=0", RegWre);
      end
    end
  end

  task automatic zero_inputs();
    Rst = 1'b0; AluWre = 1'b0; AluReg = '0; AluData = '0;
    LoadIssue = 1'b0; LoadReg = '0; LoadValid = 1'b0; LoadData = '0;
  endtask

  task automatic tick();
    @(posedge Clk); #1;
    zero_inputs();
  endtask

  task automatic drive(input logic alu, input logic [3:0] areg,
                       input logic [15:0] adata, input logic iss,
                       input logic [3:0] lreg, input logic lv,
                       input logic [15:0] ldata);
    bit  acc;
    bit  full;
    wr_t e;
    @(negedge Clk); #1;
    AluWre = alu; AluReg = areg; AluData = adata;
    LoadIssue = iss; LoadReg = lreg; LoadValid = lv; LoadData = ldata;
    acc  = lv && (mq.size() > 0) && !alu;
    full = (mq.size() == DEPTH);
    if (alu) begin
      e.r = areg; e.d = adata; sb.push_back(e);
    end else if (acc) begin
      e.r = mq[0]; e.d = ldata; sb.push_back(e);
    end
    if (acc) mq.delete(0);
    if (iss && !full) mq.push_back(lreg);
    #1;
  endtask

  task automatic do_reset();
    @(negedge Clk); #1;
    Rst = 1'b1; AluWre = 1'b1; AluReg = 4'd5; AluData = 16'hFFFF;
    LoadIssue = 1'b1; LoadReg = 4'd9; LoadValid = 1'b1; LoadData = 16'hDEAD;
    #1;
    checks++;
    if (LoadAccept !== 1'b0) begin
      failures++;
      $display("FAIL accept_in_reset got=%b exp=0", LoadAccept);
    end
    mq.delete();
    sb.delete();
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({RegWre, WriteReg, WriteData, Busy, Stall, Err} !== 39'd0) begin
      failures++;
      $display("FAIL reset_state got=%b/%h/%h/%h/%b/%b exp=0",
               RegWre, WriteReg, WriteData, Busy, Stall, Err);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_alu();
    drive(1, 4'd3, 16'h1234, 0, 0, 0, 0);
    tick();
    drive(1, 4'd0, 16'h0F0F, 0, 0, 0, 0);
    tick();
    tick();
    checks++;
    if (WriteReg !== 4'd0 || WriteData !== 16'h0F0F) begin
      failures++;
      $display("FAIL alu_hold got=%h/%h exp=0/0f0f", WriteReg, WriteData);
    end
    checks++;
    if (Err !== 1'b0) begin
      failures++;
      $display("FAIL alu_err got=%b exp=0", Err);
    end
  endtask

  task automatic test_load_order();
    drive(0, 0, 0, 1, 4'd5, 0, 0);
    tick();
    checks++;
    if (Stall !== 1'b0 || Busy !== 16'h0020) begin
      failures++;
      $display("FAIL order_one got=%b/%h exp=0/0020", Stall, Busy);
    end
    drive(0, 0, 0, 1, 4'd6, 0, 0);
    tick();
    checks++;
    if (Stall !== 1'b1 || Busy !== 16'h0060) begin
      failures++;
      $display("FAIL order_full got=%b/%h exp=1/0060", Stall, Busy);
    end
    drive(0, 0, 0, 0, 0, 1, 16'hAAAA);
    checks++;
    if (LoadAccept !== 1'b1) begin
      failures++;
      $display("FAIL order_accept got=%b exp=1", LoadAccept);
    end
    tick();
    checks++;
    if (Stall !== 1'b0 || Busy !== 16'h0040) begin
      failures++;
      $display("FAIL order_pop1 got=%b/%h exp=0/0040", Stall, Busy);
    end
    drive(0, 0, 0, 0, 0, 1, 16'hBBBB);
    tick();
    checks++;
    if (Stall !== 1'b0 || Busy !== 16'h0000 || Err !== 1'b0) begin
      failures++;
      $display("FAIL order_done got=%b/%h/%b exp=0/0000/0", Stall, Busy, Err);
    end
  endtask

  task automatic test_conflict();
    drive(0, 0, 0, 1, 4'd7, 0, 0);
    tick();
    drive(1, 4'd2, 16'h2222, 0, 0, 1, 16'hCCCC);
    checks++;
    if (LoadAccept !== 1'b0) begin
      failures++;
      $display("FAIL conflict_refuse got=%b exp=0", LoadAccept);
    end
    tick();
    drive(0, 0, 0, 0, 0, 1, 16'hCCCC);
    checks++;
    if (LoadAccept !== 1'b1) begin
      failures++;
      $display("FAIL conflict_retry got=%b exp=1", LoadAccept);
    end
    tick();
    tick();
    checks++;
    if (Busy !== 16'h0000 || Err !== 1'b0) begin
      failures++;
      $display("FAIL conflict_end got=%h/%b exp=0000/0", Busy, Err);
    end
  endtask

  task automatic test_push_pop();
    drive(0, 0, 0, 1, 4'd1, 0, 0);
    tick();
    drive(0, 0, 0, 1, 4'd8, 1, 16'hDDDD);
    tick();
    checks++;
    if (Stall !== 1'b0 || Busy !== 16'h0100) begin
      failures++;
      $display("FAIL pushpop got=%b/%h exp=0/0100", Stall, Busy);
    end
    drive(0, 0, 0, 0, 0, 1, 16'hEEEE);
    tick();
    checks++;
    if (Busy !== 16'h0000) begin
      failures++;
      $display("FAIL pushpop_end got=%h exp=0000", Busy);
    end
  endtask

  task automatic test_errors();
    drive(0, 0, 0, 0, 0, 1, 16'h5A5A);
    checks++;
    if (LoadAccept !== 1'b0) begin
      failures++;
      $display("FAIL empty_accept got=%b exp=0", LoadAccept);
    end
    tick();
    tick();
    checks++;
    if (Err !== 1'b1) begin
      failures++;
      $display("FAIL empty_err got=%b exp=1", Err);
    end
    do_reset();
    drive(0, 0, 0, 1, 4'd5, 0, 0);
    tick();
    drive(0, 0, 0, 1, 4'd6, 0, 0);
    tick();
    drive(0, 0, 0, 1, 4'd9, 0, 0);
    tick();
    checks++;
    if (Err !== 1'b1 || Busy !== 16'h0060 || Stall !== 1'b1) begin
      failures++;
      $display("FAIL stall_drop got=%b/%h/%b exp=1/0060/1", Err, Busy, Stall);
    end
    do_reset();
    drive(0, 0, 0, 1, 4'd5, 0, 0);
    tick();
    checks++;
    if (Err !== 1'b0) begin
      failures++;
      $display("FAIL waw_pre got=%b exp=0", Err);
    end
    drive(1, 4'd5, 16'h5555, 0, 0, 0, 0);
    tick();
    checks++;
    if (Err !== 1'b1 || Busy !== 16'h0020) begin
      failures++;
      $display("FAIL waw got=%b/%h exp=1/0020", Err, Busy);
    end
    do_reset();
  endtask

  task automatic test_same_reg();
    drive(0, 0, 0, 1, 4'd4, 0, 0);
    tick();
    drive(0, 0, 0, 1, 4'd4, 0, 0);
    tick();
    checks++;
    if (Busy !== 16'h0010) begin
      failures++;
      $display("FAIL same_both got=%h exp=0010", Busy);
    end
    drive(0, 0, 0, 0, 0, 1, 16'h1111);
    tick();
    checks++;
    if (Busy !== 16'h0010) begin
      failures++;
      $display("FAIL same_first got=%h exp=0010", Busy);
    end
    drive(0, 0, 0, 0, 0, 1, 16'h2222);
    tick();
    checks++;
    if (Busy !== 16'h0000 || Err !== 1'b0) begin
      failures++;
      $display("FAIL same_second got=%h/%b exp=0000/0", Busy, Err);
    end
  endtask

  task automatic test_reset_midflight();
    drive(0, 0, 0, 1, 4'd3, 0, 0);
    tick();
    do_reset();
    checks++;
    if (Busy !== 16'h0000 || Stall !== 1'b0 || Err !== 1'b0 || RegWre !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got=%h/%b/%b/%b exp=0000/0/0/0",
               Busy, Stall, Err, RegWre);
    end
    drive(0, 0, 0, 0, 0, 1, 16'h3333);
    checks++;
    if (LoadAccept !== 1'b0) begin
      failures++;
      $display("FAIL mid_accept got=%b exp=0", LoadAccept);
    end
    tick();
    checks++;
    if (Err !== 1'b1) begin
      failures++;
      $display("FAIL mid_err got=%b exp=1", Err);
    end
  endtask

  initial begin
    zero_inputs();
    test_reset();
    test_alu();
    test_load_order();
    test_conflict();
    test_push_pop();
    test_errors();
    test_same_reg();
    test_reset_midflight();
    tick();
    tick();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 SHALL have parameter LQ_DEPTH, default 2: load-tag queue depth, a power of two, 2..8.
REQ-002 SHALL have port Clk, input, 1 bit: single clock; all state updates on posedge.
REQ-003 SHALL have port Rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port AluWre, input, 1 bit: ALU result valid this cycle, always accepted.
REQ-005 SHALL have port AluReg, input, 4 bits: ALU destination register.
REQ-006 SHALL have port AluData, input, 16 bits: ALU result.
REQ-007 SHALL have port LoadIssue, input, 1 bit: load issued to memory, destination in LoadReg.
REQ-008 SHALL have port LoadReg, input, 4 bits: load destination register.
REQ-009 SHALL have port LoadValid, input, 1 bit: memory returns load data, in issue order.
REQ-010 SHALL have port LoadData, input, 16 bits: returned load data.
REQ-011 SHALL have port LoadAccept, output, 1 bit, combinational: return consumed this cycle.
REQ-012 SHALL have port Stall, output, 1 bit, registered: tag queue full, LoadIssue refused.
REQ-013 SHALL have port RegWre, output, 1 bit, registered: register-file write enable.
REQ-014 SHALL have ports WriteReg (output, 4 bits) and WriteData (output, 16 bits), registered: write address and data.
REQ-015 SHALL have port Busy, output, 16 bits, registered: bit n set while a load to register n is outstanding.
REQ-016 SHALL have port Err, output, 1 bit, registered, sticky: protocol/hazard violation seen.

Function
REQ-017 Tag queue: FIFO of LQ_DEPTH 4-bit destinations plus occupancy count 0..LQ_DEPTH, pointers wrap modulo LQ_DEPTH.
REQ-018 Push SHALL occur on posedge when LoadIssue=1 and Stall=0; LoadIssue while Stall=1 SHALL be dropped and set Err.
REQ-019 Stall SHALL equal (count==LQ_DEPTH) after each update; a pop in the same cycle SHALL NOT unblock a push in that cycle.
REQ-020 Write-port arbitration, per cycle: AluWre=1 wins; otherwise a load return wins if LoadValid=1 and count>0.
REQ-021 LoadAccept SHALL be LoadValid & (count>0) & ~AluWre; a refused return SHALL be held by memory and retried.
REQ-022 LoadValid with count==0 SHALL NOT be accepted, SHALL NOT write, and SHALL set Err.
REQ-023 On accept, next cycle: RegWre=1, WriteReg=queue head, WriteData=LoadData; head popped.
REQ-024 On AluWre, next cycle: RegWre=1, WriteReg=AluReg, WriteData=AluData; otherwise RegWre=0 with WriteReg/WriteData held.
REQ-025 Latency SHALL be exactly one cycle from accepted input to RegWre; the register file commits on the following negedge.
REQ-026 Writes to index 0 SHALL pass through unfiltered; REG0/T/PC semantics stay in the register file.
REQ-027 Busy[LoadReg] SHALL set on push; Busy[head] SHALL clear on pop; if one register is both set and cleared in a cycle, set SHALL win.
REQ-028 Busy SHALL clear only when no other queued entry targets that register (per-register pending counter, width log2(LQ_DEPTH)+1).
REQ-029 AluWre to a register whose Busy bit is set (WAW) SHALL perform the write and set Err.
REQ-030 Simultaneous push and pop with 0<count<LQ_DEPTH SHALL keep count unchanged and FIFO order intact.

Reset
REQ-031 With Rst=1 at posedge: count=0, pointers=0, Stall=0, RegWre=0, WriteReg=0, WriteData=0, Busy=0, Err=0, pending counters=0.
REQ-032 Reset SHALL discard queued tags mid-operation; LoadAccept SHALL be 0 while Rst=1.
REQ-033 Inputs during a reset cycle SHALL be ignored entirely.

Verification
REQ-034 ALU path: AluWre=1, AluReg=3, AluData=16'h1234 -> next cycle RegWre=1, WriteReg=3, WriteData=16'h1234; following cycle with AluWre=0 -> RegWre=0.
REQ-035 Load order: issue LoadReg=5 then 6 (LQ_DEPTH=2) -> Stall=1, Busy=16'h0060; returns 16'hAAAA then 16'hBBBB -> writes r5=AAAA then r6=BBBB; Busy=0, Stall=0.
REQ-036 Conflict: AluWre=1 (reg 2) and LoadValid=1 in the same cycle -> LoadAccept=0, reg 2 written; next cycle the load is accepted and written one cycle later.
REQ-037 Errors: LoadValid with an empty queue -> LoadAccept=0, no write, Err=1 sticky; LoadIssue while Stall=1 -> dropped, Err=1; AluWre to busy reg 5 -> written, Err=1.
REQ-038 Same-register overlap: two loads to reg 4 -> Busy[4] stays 1 after the first pop, clears after the second.
REQ-039 Reset mid-flight: one load queued, Rst=1 for one cycle -> Busy=0, count=0, Err=0; a subsequent LoadValid -> LoadAccept=0, Err=1.
